// File: rtl/turf_pkg.sv
// Shared command codes, scan codes and key-map helper for the PS/2 key path.
// The TURF_PS2_PARITY_EN macro (see ps2_rx) enables the odd-parity check.
package turf_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [4:0] KEY_P1_UP    = 5'd0;
  localparam logic [4:0] KEY_P1_DOWN  = 5'd1;
  localparam logic [4:0] KEY_P1_LEFT  = 5'd2;
  localparam logic [4:0] KEY_P1_RIGHT = 5'd3;
  localparam logic [4:0] KEY_P2_UP    = 5'd4;
  localparam logic [4:0] KEY_P2_DOWN  = 5'd5;
  localparam logic [4:0] KEY_P2_LEFT  = 5'd6;
  localparam logic [4:0] KEY_P2_RIGHT = 5'd7;
  localparam logic [4:0] KEY_P3_UP    = 5'd8;
  localparam logic [4:0] KEY_P3_DOWN  = 5'd9;
  localparam logic [4:0] KEY_P3_LEFT  = 5'd10;
  localparam logic [4:0] KEY_P3_RIGHT = 5'd11;
  localparam logic [4:0] KEY_P4_UP    = 5'd12;
  localparam logic [4:0] KEY_P4_DOWN  = 5'd13;
  localparam logic [4:0] KEY_P4_LEFT  = 5'd14;
  localparam logic [4:0] KEY_P4_RIGHT = 5'd15;
  localparam logic [4:0] KEY_RESET    = 5'd16;
  localparam logic [4:0] KEY_IDLE     = 5'd31;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_W        = 8'h1D;
  localparam logic [7:0] SC_S        = 8'h1B;
  localparam logic [7:0] SC_A        = 8'h1C;
  localparam logic [7:0] SC_D        = 8'h23;
  localparam logic [7:0] SC_I        = 8'h43;
  localparam logic [7:0] SC_K        = 8'h42;
  localparam logic [7:0] SC_J        = 8'h3B;
  localparam logic [7:0] SC_L        = 8'h4B;
  localparam logic [7:0] SC_KP_UP    = 8'h75;
  localparam logic [7:0] SC_KP_DOWN  = 8'h72;
  localparam logic [7:0] SC_KP_LEFT  = 8'h6B;
  localparam logic [7:0] SC_KP_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE    = 8'h29;

  // Arrow keys and keypad share make codes; only the E0 prefix tells them apart.
  function automatic logic [4:0] map_key(input logic ext, input logic [7:0] sc);
    logic [4:0] code;
    code = KEY_IDLE;
    if (ext) begin
      case (sc)
        SC_KP_UP:    code = KEY_P2_UP;
        SC_KP_DOWN:  code = KEY_P2_DOWN;
        SC_KP_LEFT:  code = KEY_P2_LEFT;
        SC_KP_RIGHT: code = KEY_P2_RIGHT;
        default:     code = KEY_IDLE;
      endcase
    end else begin
      case (sc)
        SC_W:        code = KEY_P1_UP;
        SC_S:        code = KEY_P1_DOWN;
        SC_A:        code = KEY_P1_LEFT;
        SC_D:        code = KEY_P1_RIGHT;
        SC_I:        code = KEY_P3_UP;
        SC_K:        code = KEY_P3_DOWN;
        SC_J:        code = KEY_P3_LEFT;
        SC_L:        code = KEY_P3_RIGHT;
        SC_KP_UP:    code = KEY_P4_UP;
        SC_KP_DOWN:  code = KEY_P4_DOWN;
        SC_KP_LEFT:  code = KEY_P4_LEFT;
        SC_KP_RIGHT: code = KEY_P4_RIGHT;
        SC_SPACE:    code = KEY_RESET;
        default:     code = KEY_IDLE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchroniser, bit FSM, mid-frame timeout, parity/stop check.
// Odd-parity checking is enabled by defining TURF_PS2_PARITY_EN.
//   state     | meaning
//   RX_IDLE   | waiting for a start bit (data=0 on a falling edge)
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | capturing the parity bit
//   RX_STOP   | capturing the stop bit, accepting or rejecting the byte
module ps2_rx
  import turf_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef TURF_PS2_PARITY_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  logic [1:0]   clk_sync;
  logic [1:0]   dat_sync;
  logic         clk_prev;
  logic         fall;
  logic         din;
  rx_state_e    state, state_n;
  logic [2:0]   bit_cnt, bit_cnt_n;
  logic [7:0]   shift, shift_n;
  logic         par, par_n;
  logic [TW-1:0] timer, timer_n;
  logic         timeout;
  logic         parity_ok;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      timer    <= '0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_prev <= clk_sync[1];
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par      <= par_n;
      timer    <= timer_n;
    end
  end

  assign fall      = clk_prev & ~clk_sync[1];
  assign din       = dat_sync[1];
  assign timeout   = (state != RX_IDLE) && (timer == TW'(TIMEOUT_CYCLES - 1));
  // With checking disabled the parity bit is still captured but never rejects a byte.
  assign parity_ok = (^{shift, par}) | ~PARITY_CHECK;
  assign byte_data = shift;

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_n      = par;
    timer_n    = timer;
    byte_valid = 1'b0;
    err        = 1'b0;
    if (fall) begin
      timer_n = '0;
      case (state)
        RX_IDLE: begin
          if (!din) begin
            state_n   = RX_DATA;
            bit_cnt_n = '0;
          end
        end
        RX_DATA: begin
          shift_n   = {din, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
        RX_PARITY: begin
          par_n   = din;
          state_n = RX_STOP;
        end
        RX_STOP: begin
          state_n = RX_IDLE;
          if (din && parity_ok) byte_valid = 1'b1;
          else                  err        = 1'b1;
        end
        default: state_n = RX_IDLE;
      endcase
    end else if (state == RX_IDLE) begin
      timer_n = '0;
    end else if (timeout) begin
      state_n = RX_IDLE;
      timer_n = '0;
      err     = 1'b1;
    end else begin
      timer_n = timer + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to game command decoder: E0/F0 prefix tracking, key map, output pulses.
// TURF_PS2_PARITY_EN (passed through to ps2_rx) enables odd-parity rejection.
module ps2_key_decoder
  import turf_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_strobe,
  output logic       frame_err
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       ext;
  logic       brk;
  logic [4:0] mapped;
  logic       key_hit;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .err       (rx_err)
  );

  assign mapped  = map_key(ext, rx_data);
  assign key_hit = rx_valid && !brk && (rx_data != SC_EXT) && (rx_data != SC_BREAK)
                   && (mapped != KEY_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      KEY_PRESSED <= KEY_IDLE;
      key_strobe  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      KEY_PRESSED <= key_hit ? mapped : KEY_IDLE;
      key_strobe  <= key_hit;
      frame_err   <= rx_err;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid) begin
        // Prefixes accumulate; any other byte ends the sequence (break codes are swallowed).
        if (rx_data == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_data == SC_BREAK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule
